// File: rtl/digitizer_pkg.sv
// Shared definitions for the digitizer FIFO readers: reader FSM encoding and
// a constant-evaluable ceil(log2) helper.
package digitizer_pkg;

  typedef logic [1:0] reader_state_t;

  localparam reader_state_t ST_IDLE     = 2'd0;
  localparam reader_state_t ST_RUN      = 2'd1;
  localparam reader_state_t ST_STOPPING = 2'd2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry valid/ready buffer. The writer has no back-pressure and must keep
// its own credit from the occupancy output so the buffer never overflows.
module stream_skid_buf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            occupancy
);

  logic [DATA_WIDTH-1:0] head_reg, head_next;
  logic [DATA_WIDTH-1:0] tail_reg, tail_next;
  logic [1:0]            occ_reg, occ_next;
  logic                  pop;

  always_comb begin
    pop       = (occ_reg != 2'd0) && m_ready;
    head_next = head_reg;
    tail_next = tail_reg;
    occ_next  = occ_reg;
    case (occ_reg)
      2'd0: begin
        if (s_valid) begin
          head_next = s_data;
          occ_next  = 2'd1;
        end
      end
      2'd1: begin
        if (s_valid && pop) begin
          head_next = s_data;
        end else if (s_valid) begin
          tail_next = s_data;
          occ_next  = 2'd2;
        end else if (pop) begin
          occ_next  = 2'd0;
        end
      end
      default: begin
        // Full: head only advances on a pop; a same-cycle write refills the tail.
        if (pop) begin
          head_next = tail_reg;
          if (s_valid) tail_next = s_data;
          else         occ_next  = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_reg <= '0;
      tail_reg <= '0;
      occ_reg  <= 2'd0;
    end else begin
      head_reg <= head_next;
      tail_reg <= tail_next;
      occ_reg  <= occ_next;
    end
  end

  assign m_valid   = (occ_reg != 2'd0);
  assign m_data    = head_reg;
  assign occupancy = occ_reg;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side controller for a non-FWFT FIFO: issues reads under a 2-word credit,
// buffers the 1-cycle-late Q data and emits a framed valid/ready stream.
module fifo_stream_reader
  import digitizer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 256,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_q,
  output logic                  fifo_re,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  frame_cnt
);

  localparam int IDX_W = (FRAME_LEN > 1) ? clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  reader_state_t          state_reg, state_next;
  logic [IDX_W-1:0]       rd_idx_reg, rd_idx_next;
  logic [IDX_W-1:0]       out_idx_reg, out_idx_next;
  logic                   in_flight_reg;
  logic [CNT_WIDTH-1:0]   frame_cnt_reg, frame_cnt_next;
  logic [1:0]             occupancy;
  logic [2:0]             level;
  logic                   xfer;
  logic                   rd_wrap;

  stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_valid   (in_flight_reg),
    .s_data    (fifo_q),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .occupancy (occupancy)
  );

  always_comb begin
    xfer    = m_valid && m_ready;
    // Words that will still be held after this cycle's departure, plus the one in flight.
    level   = 3'(occupancy) + 3'(in_flight_reg) - 3'(xfer);
    fifo_re = (state_reg != ST_IDLE) && !fifo_empty && (level < 3'd2);
    rd_wrap = fifo_re && (rd_idx_reg == LAST_IDX);

    rd_idx_next = rd_idx_reg;
    if (fifo_re) rd_idx_next = rd_wrap ? '0 : rd_idx_reg + IDX_W'(1);

    out_idx_next   = out_idx_reg;
    frame_cnt_next = frame_cnt_reg;
    if (xfer) begin
      out_idx_next = (out_idx_reg == LAST_IDX) ? '0 : out_idx_reg + IDX_W'(1);
      if (m_last) frame_cnt_next = frame_cnt_reg + CNT_WIDTH'(1);
    end

    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (enable) state_next = ST_RUN;
      end
      ST_RUN: begin
        // Decide on the post-read index so a read issued this cycle is never orphaned.
        if (!enable) state_next = (rd_idx_next == '0) ? ST_IDLE : ST_STOPPING;
      end
      ST_STOPPING: begin
        if (enable)       state_next = ST_RUN;
        else if (rd_wrap) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      rd_idx_reg    <= '0;
      out_idx_reg   <= '0;
      in_flight_reg <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      rd_idx_reg    <= rd_idx_next;
      out_idx_reg   <= out_idx_next;
      in_flight_reg <= fifo_re;
      frame_cnt_reg <= frame_cnt_next;
    end
  end

  assign m_last    = m_valid && (out_idx_reg == LAST_IDX);
  assign busy      = (state_reg != ST_IDLE) || in_flight_reg || (occupancy != 2'd0);
  assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized bench for fifo_stream_reader against a queue-based FIFO and stream model.
module tb_fifo_stream_reader;

  localparam int DW = 32;
  localparam int FL = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          fifo_empty;
  logic [DW-1:0] fifo_q;
  logic          fifo_re;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic [CW-1:0] frame_cnt;

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .DATA_WIDTH (DW),
    .FRAME_LEN  (FL),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_q     (fifo_q),
    .fifo_re    (fifo_re),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  logic [DW-1:0] fifo_mem[$];
  logic [DW-1:0] exp_q[$];
  int occ_m, infl_m, out_cnt, rd_cnt, fcnt_m, cyc;
  int first_re, first_v, first_x, last_x;
  int ready_mode;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_mem.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic cycle();
    logic re, v, l, x;
    logic [DW-1:0] d, w;
    @(negedge clk);
    re = fifo_re;
    v  = m_valid;
    d  = m_data;
    l  = m_last;
    x  = v && m_ready;
    check_eq("valid", v, occ_m != 0);
    check_eq("last", l, v && ((out_cnt % FL) == FL - 1));
    check_eq("fcnt", frame_cnt, fcnt_m % (1 << CW));
    check_eq("re_empty", re && fifo_empty, 0);
    check_eq("re_credit", re && ((occ_m - x + infl_m) >= 2), 0);
    if (v && exp_q.size() > 0) check_eq("data", d, exp_q[0]);
    if (re && first_re < 0) first_re = cyc;
    if (v && first_v < 0) first_v = cyc;
    if (x) begin
      if (first_x < 0) first_x = cyc;
      last_x = cyc;
    end
    @(posedge clk);
    if (x) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if ((out_cnt % FL) == FL - 1) fcnt_m++;
      out_cnt++;
    end
    occ_m  = occ_m - int'(x) + infl_m;
    infl_m = int'(re);
    #1;
    if (re) begin
      w = 32'hDEAD_BEEF;
      if (fifo_mem.size() > 0) w = fifo_mem.pop_front();
      fifo_q = w;
      exp_q.push_back(w);
      rd_cnt++;
    end
    fifo_empty = (fifo_mem.size() == 0);
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      2:       m_ready = ($urandom_range(0, 2) != 0);
      default: m_ready = 1'b0;
    endcase
    cyc++;
  endtask

  task automatic clear_model();
    fifo_mem.delete();
    exp_q.delete();
    occ_m = 0; infl_m = 0; out_cnt = 0; rd_cnt = 0; fcnt_m = 0;
    first_re = -1; first_v = -1; first_x = -1; last_x = -1;
    fifo_empty = 1'b1;
    fifo_q = '0;
    enable = 1'b0;
    m_ready = 1'b1;
    ready_mode = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic run_until_idle(input int max_cyc, input string tag);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < max_cyc) begin
      cycle();
      n++;
    end
    check_eq(tag, n < max_cyc, 1);
  endtask

  initial begin
    int n;
    cyc = 0;
    reset_n = 1'b0;
    clear_model();
    #2;
    check_eq("rst_re", fifo_re, 0);
    check_eq("rst_valid", m_valid, 0);
    check_eq("rst_data", m_data, 0);
    check_eq("rst_last", m_last, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_fcnt", frame_cnt, 0);

    // 1: preloaded 0..7, full throughput
    do_reset();
    for (int i = 0; i < 8; i++) push_word(DW'(i));
    enable = 1'b1;
    repeat (14) cycle();
    check_eq("t1_words", out_cnt, 8);
    check_eq("t1_latency", first_v - first_re, 2);
    check_eq("t1_back2back", last_x - first_x, 7);
    check_eq("t1_fcnt", frame_cnt, 2);
    $display("[TB] test1 words=%0d fcnt=%0d", out_cnt, frame_cnt);

    // 2: ready toggling 1,0,0,1
    do_reset();
    for (int i = 0; i < 8; i++) push_word(DW'(i));
    ready_mode = 1;
    m_ready = 1'b1;
    enable = 1'b1;
    repeat (30) cycle();
    check_eq("t2_words", out_cnt, 8);
    $display("[TB] test2 words=%0d fcnt=%0d", out_cnt, frame_cnt);

    // 3: enable drops after 2 reads, frame must complete
    do_reset();
    for (int i = 0; i < 8; i++) push_word(DW'(100 + i));
    enable = 1'b1;
    n = 0;
    while (rd_cnt < 2 && n < 10) begin cycle(); n++; end
    check_eq("t3_start", rd_cnt, 2);
    enable = 1'b0;
    run_until_idle(40, "t3_idle_timeout");
    check_eq("t3_reads", rd_cnt, 4);
    check_eq("t3_words", out_cnt, 4);
    repeat (10) cycle();
    check_eq("t3_reads_after", rd_cnt, 4);
    check_eq("t3_busy", busy, 0);
    $display("[TB] test3 reads=%0d words=%0d", rd_cnt, out_cnt);

    // 4: FIFO empties after 5 words, refilled 10 clocks later
    do_reset();
    for (int i = 0; i < 5; i++) push_word($urandom);
    enable = 1'b1;
    repeat (12) cycle();
    check_eq("t4_partial", out_cnt, 5);
    repeat (10) cycle();
    for (int i = 0; i < 3; i++) push_word($urandom);
    repeat (10) cycle();
    check_eq("t4_words", out_cnt, 8);
    check_eq("t4_fcnt", frame_cnt, 2);
    enable = 1'b0;
    run_until_idle(20, "t4_idle_timeout");
    $display("[TB] test4 words=%0d fcnt=%0d", out_cnt, frame_cnt);

    // 5: reset with the buffer full mid-frame
    do_reset();
    for (int i = 0; i < 8; i++) push_word($urandom);
    ready_mode = 3;
    m_ready = 1'b0;
    enable = 1'b1;
    repeat (6) cycle();
    check_eq("t5_full", occ_m, 2);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t5_re", fifo_re, 0);
    check_eq("t5_valid", m_valid, 0);
    check_eq("t5_data", m_data, 0);
    check_eq("t5_last", m_last, 0);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_fcnt", frame_cnt, 0);
    clear_model();
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) push_word($urandom);
    enable = 1'b1;
    repeat (10) cycle();
    check_eq("t5_frame", frame_cnt, 1);
    enable = 1'b0;
    run_until_idle(20, "t5_idle_timeout");
    $display("[TB] test5 words=%0d fcnt=%0d", out_cnt, frame_cnt);

    // 6: 17 frames wrap a 4-bit frame counter
    do_reset();
    for (int i = 0; i < 17 * FL; i++) push_word($urandom);
    ready_mode = 2;
    enable = 1'b1;
    n = 0;
    while (out_cnt < 17 * FL && n < 600) begin cycle(); n++; end
    check_eq("t6_words", out_cnt, 17 * FL);
    enable = 1'b0;
    run_until_idle(20, "t6_idle_timeout");
    check_eq("t6_fcnt_wrap", frame_cnt, 1);
    $display("[TB] test6 words=%0d fcnt=%0d", out_cnt, frame_cnt);

    // 7: random enable, ready and FIFO fill; frames must stay whole
    do_reset();
    ready_mode = 2;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1 && fifo_mem.size() < 20) push_word($urandom);
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      cycle();
    end
    enable = 1'b0;
    for (int i = 0; i < FL; i++) push_word($urandom);
    run_until_idle(200, "t7_idle_timeout");
    check_eq("t7_frame_whole", rd_cnt % FL, 0);
    check_eq("t7_drained", out_cnt, rd_cnt);
    $display("[TB] test7 reads=%0d words=%0d fcnt=%0d", rd_cnt, out_cnt, frame_cnt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
